// File: rtl/tlul_pkg.sv
// TL-UL types, error-response constants and gate state encoding.
package tlul_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned IntgW  = 7;

  // Data returned with every locally generated error response.
  localparam logic [TL_DW-1:0] ErrRspData = '1;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [IntgW-1:0] cmd_intg;
    logic [IntgW-1:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [IntgW-1:0] rsp_intg;
    logic [IntgW-1:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [TL_DW-1:0]  d_data;
    tl_d_user_t        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  // One-hot so a single flipped state bit never aliases a legal state.
  typedef enum logic [3:0] {
    PASS   = 4'b0001,
    DRAIN  = 4'b0010,
    ACCEPT = 4'b0100,
    RESP   = 4'b1000
  } gate_state_e;

  // D opcode owed for a given A opcode.
  function automatic tl_d_op_e rsp_opcode(input tl_a_op_e op);
    return (op == Get) ? AccessAckData : AccessAck;
  endfunction

endpackage

// File: rtl/tlul_rsp_intg_gen.sv
// Response and data integrity for the locally generated error response.
module tlul_rsp_intg_gen
  import tlul_pkg::*;
(
  input  tl_d_op_e          opcode,
  input  logic [TL_SZW-1:0] size,
  input  logic [TL_AIW-1:0] source,
  input  logic              error,
  input  logic [TL_DW-1:0]  data,
  output tl_d_user_t        user
);

  localparam logic [IntgW-1:0][TL_DW-1:0] Mask = {
    32'h8F19_D65C, 32'h79A4_37E2, 32'hC672_4B1D, 32'h3C8F_E1A5,
    32'hA1D7_9E46, 32'h5B6D_2C38, 32'h0E3C_5A97
  };

  function automatic logic [IntgW-1:0] encode(input logic [TL_DW-1:0] word);
    logic [IntgW-1:0] code;
    code = '0;
    for (int unsigned i = 0; i < IntgW; i++) code[i] = ^(word & Mask[i]);
    return code;
  endfunction

  logic [TL_DW-1:0] rsp_word;

  // Parity code over the response header and over the data word.
  always_comb begin
    rsp_word       = TL_DW'({opcode, size, source, error});
    user.rsp_intg  = encode(rsp_word);
    user.data_intg = encode(data);
  end

endmodule

// File: rtl/tlul_intg_err_gate.sv
// Blocks integrity-flagged TL-UL requests, drains the device and answers them locally with an error.
module tlul_intg_err_gate
  import tlul_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned ErrCntWidth    = 8,
  parameter bit          FatalLatch     = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  tl_h2d_t                tl_h_i,
  output tl_d2h_t                tl_h_o,
  output tl_h2d_t                tl_d_o,
  input  tl_d2h_t                tl_d_i,
  input  logic                   chk_en_i,
  input  logic                   intg_err_i,
  output logic                   alert_req_o,
  input  logic                   alert_ack_i,
  output logic                   fatal_o,
  output logic [ErrCntWidth-1:0] err_cnt_o
);

  localparam int unsigned     OutW   = $clog2(MaxOutstanding + 1);
  localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

  gate_state_e             state;
  logic [OutW-1:0]         outstanding, outstanding_next;
  logic                    fatal, alert;
  logic [ErrCntWidth-1:0]  err_cnt;
  tl_d_op_e                cap_op;
  logic [TL_SZW-1:0]       cap_size;
  logic [TL_AIW-1:0]       cap_source;
  logic                    bad, new_err, room, inc, dec;
  tl_d_user_t              rsp_user;

  assign bad     = tl_h_i.a_valid & chk_en_i & (intg_err_i | fatal);
  assign new_err = (state == PASS) & tl_h_i.a_valid & chk_en_i & intg_err_i;
  assign room    = outstanding < MaxOut;
  assign inc     = tl_d_o.a_valid & tl_d_i.a_ready;
  assign dec     = tl_d_i.d_valid & tl_d_o.d_ready;

  assign alert_req_o = alert;
  assign fatal_o     = fatal;
  assign err_cnt_o   = err_cnt;

  tlul_rsp_intg_gen u_rsp_intg (
    .opcode (cap_op),
    .size   (cap_size),
    .source (cap_source),
    .error  (1'b1),
    .data   (ErrRspData),
    .user   (rsp_user)
  );

  // Device side: forward clean requests in PASS only, within the in-flight limit.
  always_comb begin
    tl_d_o         = tl_h_i;
    tl_d_o.a_valid = (state == PASS) & tl_h_i.a_valid & ~bad & room;
    tl_d_o.d_ready = (state != RESP) & tl_h_i.d_ready;
  end

  // Host side: device D passes through except while the local error response is driven.
  always_comb begin
    tl_h_o = tl_d_i;
    unique case (state)
      PASS:    tl_h_o.a_ready = tl_d_i.a_ready & ~bad & room;
      DRAIN:   tl_h_o.a_ready = 1'b0;
      ACCEPT:  tl_h_o.a_ready = 1'b1;
      RESP: begin
        tl_h_o.d_valid  = 1'b1;
        tl_h_o.d_opcode = cap_op;
        tl_h_o.d_param  = '0;
        tl_h_o.d_size   = cap_size;
        tl_h_o.d_source = cap_source;
        tl_h_o.d_sink   = 1'b0;
        tl_h_o.d_data   = ErrRspData;
        tl_h_o.d_user   = rsp_user;
        tl_h_o.d_error  = 1'b1;
        tl_h_o.a_ready  = 1'b0;
      end
      default: tl_h_o.a_ready = 1'b0;
    endcase
  end

  // In-flight count after this cycle's device handshakes.
  always_comb begin
    outstanding_next = outstanding;
    if (inc && !dec)      outstanding_next = outstanding + 1'b1;
    else if (dec && !inc) outstanding_next = outstanding - 1'b1;
  end

  // Error sequencer: capture the flagged request, drain, consume it, then respond.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= PASS;
      cap_op     <= AccessAck;
      cap_size   <= '0;
      cap_source <= '0;
    end else begin
      unique case (state)
        PASS: if (bad) begin
          cap_op     <= rsp_opcode(tl_h_i.a_opcode);
          cap_size   <= tl_h_i.a_size;
          cap_source <= tl_h_i.a_source;
          state      <= DRAIN;
        end
        DRAIN:   if (outstanding_next == '0) state <= ACCEPT;
        ACCEPT:  state <= RESP;
        RESP:    if (tl_h_i.d_ready) state <= PASS;
        default: state <= PASS;
      endcase
    end
  end

  // Outstanding counter, saturating error count, fatal latch and alert level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
      err_cnt     <= '0;
      fatal       <= 1'b0;
      alert       <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      alert       <= new_err | (alert & ~alert_ack_i);
      if (new_err) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (FatalLatch)    fatal   <= 1'b1;
      end
    end
  end

  a_only_in_pass: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tl_d_o.a_valid |-> (state == PASS));
  no_d_overlap: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state == RESP) |-> !tl_d_i.d_valid);
  no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dec && !inc) |-> (outstanding != '0));

endmodule

// File: tb/tb_tlul_intg_err_gate.sv
// Bench for tlul_intg_err_gate: two instances (fatal latch on/off) against a transaction-level model.
module tb_tlul_intg_err_gate;
  import tlul_pkg::*;

  typedef struct {
    tl_a_op_e   op;
    logic [7:0] src;
    logic [1:0] size;
    logic [31:0] addr;
    logic [31:0] data;
    logic       intg;
  } req_t;

  typedef struct {
    int unsigned rdy;
    tl_d_op_e    op;
    logic [7:0]  src;
    logic [1:0]  size;
  } dev_t;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  src;
    logic [1:0]  size;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tl_h2d_t    host_a[2];
  tl_d2h_t    host_d[2];
  tl_h2d_t    dev_a[2];
  tl_d2h_t    dev_d[2];
  logic       chk_en[2], intg_err[2], alert_ack[2], alert_req[2], fatal[2];
  logic [7:0] err_cnt[2];

  tlul_intg_err_gate #(.MaxOutstanding(4), .ErrCntWidth(8), .FatalLatch(1'b1)) dut_fatal (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(host_a[0]), .tl_h_o(host_d[0]),
    .tl_d_o(dev_a[0]), .tl_d_i(dev_d[0]), .chk_en_i(chk_en[0]), .intg_err_i(intg_err[0]),
    .alert_req_o(alert_req[0]), .alert_ack_i(alert_ack[0]), .fatal_o(fatal[0]),
    .err_cnt_o(err_cnt[0]));

  tlul_intg_err_gate #(.MaxOutstanding(4), .ErrCntWidth(8), .FatalLatch(1'b0)) dut_nofatal (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(host_a[1]), .tl_h_o(host_d[1]),
    .tl_d_o(dev_a[1]), .tl_d_i(dev_d[1]), .chk_en_i(chk_en[1]), .intg_err_i(intg_err[1]),
    .alert_req_o(alert_req[1]), .alert_ack_i(alert_ack[1]), .fatal_o(fatal[1]),
    .err_cnt_o(err_cnt[1]));

  req_t        hq[2][$];
  dev_t        dq[2][$];
  exp_t        eq[2][$];
  int unsigned m_err[2];
  bit          m_fatal[2], m_alert[2];
  bit          hold[2], dready_lo[2];
  int unsigned dev_beats[2];
  int unsigned base[2];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] dev_data(input logic [7:0] src);
    return {16'hD47A, 8'h00, src};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input tl_a_op_e op, input logic [7:0] src,
                      input logic [1:0] size, input logic intg);
    req_t r;
    r.op = op; r.src = src; r.size = size;
    r.addr = $urandom; r.data = $urandom; r.intg = intg;
    hq[k].push_back(r);
  endtask

  // One clock: observe settled handshakes, update the model, then drive the next cycle.
  task automatic tick();
    exp_t e;
    req_t r;
    #2;
    for (int k = 0; k < 2; k++) begin
      bit ha, hd, da, dd, merr;
      ha   = host_a[k].a_valid & host_d[k].a_ready;
      hd   = host_d[k].d_valid & host_a[k].d_ready;
      da   = dev_a[k].a_valid & dev_d[k].a_ready;
      dd   = dev_d[k].d_valid & dev_a[k].d_ready;
      merr = chk_en[k] & (intg_err[k] | m_fatal[k]);
      if (hd) begin
        if (eq[k].size() == 0) check("d_unexpected", 1, 0);
        else begin
          e = eq[k].pop_front();
          check("d_fields", {host_d[k].d_opcode, host_d[k].d_size, host_d[k].d_source, host_d[k].d_error},
                {e.op, e.size, e.src, e.err});
          check("d_data", host_d[k].d_data, e.data);
          if (!e.err) check("d_zero_latency", dd, 1);
        end
      end
      if (da) begin
        check("max_outstanding", dq[k].size() < 4, 1);
        check("dev_a_addr_data", {dev_a[k].a_address, dev_a[k].a_data},
              {host_a[k].a_address, host_a[k].a_data});
        check("dev_a_ctl", {dev_a[k].a_opcode, dev_a[k].a_size, dev_a[k].a_source, dev_a[k].a_mask},
              {host_a[k].a_opcode, host_a[k].a_size, host_a[k].a_source, host_a[k].a_mask});
        check("dev_a_clean", merr, 0);
      end
      if (dd) void'(dq[k].pop_front());
      if (da) begin
        dq[k].push_back('{rdy: cyc + 2, op: (dev_a[k].a_opcode == Get) ? AccessAckData : AccessAck,
                          src: dev_a[k].a_source, size: dev_a[k].a_size});
        dev_beats[k]++;
      end
      if (alert_ack[k]) m_alert[k] = 1'b0;
      if (ha && hq[k].size() > 0) begin
        r = hq[k].pop_front();
        if (merr) begin
          check("drained_before_accept", dq[k].size(), 0);
          if (chk_en[k] && intg_err[k]) begin
            if (m_err[k] < 255) m_err[k]++;
            if (k == 0) m_fatal[k] = 1'b1;
            m_alert[k] = 1'b1;
          end
        end
        e.op = (r.op == Get) ? 3'd1 : 3'd0;
        e.src = r.src; e.size = r.size; e.err = merr;
        e.data = merr ? 32'hFFFF_FFFF : dev_data(r.src);
        eq[k].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      dev_d[k] = '0;
      dev_d[k].a_ready = ($urandom_range(3) != 0);
      if (dq[k].size() > 0 && dq[k][0].rdy <= cyc && !hold[k]) begin
        dev_d[k].d_valid  = 1'b1;
        dev_d[k].d_opcode = dq[k][0].op;
        dev_d[k].d_size   = dq[k][0].size;
        dev_d[k].d_source = dq[k][0].src;
        dev_d[k].d_data   = dev_data(dq[k][0].src);
      end
      host_a[k] = '0;
      host_a[k].d_ready = dready_lo[k] ? 1'b0 : ($urandom_range(3) != 0);
      intg_err[k] = 1'b0;
      if (hq[k].size() > 0) begin
        r = hq[k][0];
        host_a[k].a_valid   = 1'b1;
        host_a[k].a_opcode  = r.op;
        host_a[k].a_size    = r.size;
        host_a[k].a_source  = r.src;
        host_a[k].a_address = r.addr;
        host_a[k].a_data    = r.data;
        host_a[k].a_mask    = 4'hF;
        intg_err[k]         = r.intg;
      end
    end
  endtask

  task automatic run_idle();
    int n = 0;
    while ((hq[0].size() + hq[1].size() + eq[0].size() + eq[1].size() +
            dq[0].size() + dq[1].size()) != 0 && n < 2000) begin
      tick();
      n++;
    end
    check("idle_within_budget", n < 2000, 1);
    tick();
  endtask

  task automatic check_status(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_err_cnt"}, err_cnt[k], m_err[k]);
      check({tag, "_fatal"}, fatal[k], m_fatal[k]);
      check({tag, "_alert"}, alert_req[k], m_alert[k]);
    end
  endtask

  task automatic ack_alerts();
    alert_ack[0] = 1'b1; alert_ack[1] = 1'b1;
    tick();
    alert_ack[0] = 1'b0; alert_ack[1] = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      host_a[k] = '0; dev_d[k] = '0; chk_en[k] = 1'b1; intg_err[k] = 1'b0;
      alert_ack[k] = 1'b0; hold[k] = 1'b0; dready_lo[k] = 1'b0;
      m_err[k] = 0; m_fatal[k] = 1'b0; m_alert[k] = 1'b0; dev_beats[k] = 0;
    end

    // Reset values
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      check("rst_d_valid", host_d[k].d_valid, 0);
      check("rst_dev_a_valid", dev_a[k].a_valid, 0);
    end
    check_status("rst");
    rst_n = 1'b1;
    tick();

    // Clean Gets pass straight through
    for (int k = 0; k < 2; k++) begin
      base[k] = dev_beats[k];
      for (int s = 1; s <= 3; s++) push(k, Get, 8'(s), 2'd2, 1'b0);
    end
    run_idle();
    for (int k = 0; k < 2; k++) check("clean_dev_beats", dev_beats[k] - base[k], 3);
    check_status("clean");

    // Two outstanding Puts, then a flagged Get must wait for the drain
    hold[0] = 1'b1; hold[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push(k, PutFullData, 8'h11, 2'd2, 1'b0);
      push(k, PutPartialData, 8'h12, 2'd1, 1'b0);
    end
    n = 0;
    while (!(dq[0].size() == 2 && dq[1].size() == 2) && n < 50) begin tick(); n++; end
    check("two_outstanding", n < 50, 1);
    for (int k = 0; k < 2; k++) push(k, Get, 8'h05, 2'd2, 1'b1);
    repeat (8) tick();
    for (int k = 0; k < 2; k++) begin
      check("blocked_a_ready", host_d[k].a_ready, 0);
      check("blocked_no_d", host_d[k].d_valid, 0);
      check("blocked_alert", alert_req[k], 1);
      check("blocked_err_cnt", err_cnt[k], 1);
    end
    hold[0] = 1'b0; hold[1] = 1'b0;
    run_idle();
    check_status("err1");
    ack_alerts();
    check_status("ack1");

    // Clean Put after the first error: fatal instance error-responds it
    for (int k = 0; k < 2; k++) begin base[k] = dev_beats[k]; push(k, PutFullData, 8'h07, 2'd2, 1'b0); end
    run_idle();
    for (int k = 0; k < 2; k++) check("post_err_dev_beats", dev_beats[k] - base[k], m_fatal[k] ? 0 : 1);
    check_status("post_err");

    // Checking disabled: flagged requests pass through untouched
    chk_en[0] = 1'b0; chk_en[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin base[k] = dev_beats[k]; push(k, Get, 8'h09, 2'd2, 1'b1); end
    run_idle();
    for (int k = 0; k < 2; k++) check("chk_off_dev_beats", dev_beats[k] - base[k], 1);
    check_status("chk_off");
    chk_en[0] = 1'b1; chk_en[1] = 1'b1;

    // Randomised traffic with sparse integrity errors
    for (int i = 0; i < 30; i++)
      for (int k = 0; k < 2; k++)
        push(k, ($urandom_range(2) == 0) ? Get : (($urandom_range(1) == 0) ? PutFullData : PutPartialData),
             8'($urandom), 2'($urandom_range(2)), ($urandom_range(7) == 0));
    run_idle();
    check_status("random");
    ack_alerts();
    check_status("random_ack");

    // In-flight limit while the device withholds responses
    hold[0] = 1'b1; hold[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      base[k] = dev_beats[k];
      for (int i = 0; i < 6; i++) push(k, PutFullData, 8'(8'h40 + i), 2'd2, 1'b0);
    end
    repeat (15) tick();
    for (int k = 0; k < 2; k++) check("limit_dev_beats", dev_beats[k] - base[k], m_fatal[k] ? 0 : 4);
    check("limit_a_ready", host_d[1].a_ready, 0);
    hold[0] = 1'b0; hold[1] = 1'b0;
    run_idle();
    for (int k = 0; k < 2; k++) check("limit_total_beats", dev_beats[k] - base[k], m_fatal[k] ? 0 : 6);

    // Reset during the local error response
    dready_lo[1] = 1'b1;
    push(1, Get, 8'h33, 2'd1, 1'b1);
    n = 0;
    while (host_d[1].d_valid !== 1'b1 && n < 40) begin tick(); n++; end
    check("resp_reached", host_d[1].d_valid, 1);
    check("resp_error", host_d[1].d_error, 1);
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      hq[k].delete(); dq[k].delete(); eq[k].delete();
      m_err[k] = 0; m_fatal[k] = 1'b0; m_alert[k] = 1'b0; dready_lo[k] = 1'b0;
      check("mid_rst_d_valid", host_d[k].d_valid, 0);
      check("mid_rst_dev_a_valid", dev_a[k].a_valid, 0);
    end
    check_status("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin base[k] = dev_beats[k]; push(k, Get, 8'h21, 2'd2, 1'b0); end
    run_idle();
    for (int k = 0; k < 2; k++) check("after_rst_dev_beats", dev_beats[k] - base[k], 1);
    check_status("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
